avs_i2s_rx: RTL

//  Avalon-MM slave I2S receiver: the capture-side counterpart of our I2S transmitter slave.

---
 rtl/i2s_pkg.sv | 35 +++
 rtl/avs_i2s_rx_if.sv | 14 +
 rtl/i2s_rx_fifo.sv | 50 +++++
 rtl/avs_i2s_rx.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S slave peripherals: register map, bit positions, FSM states.
package i2s_pkg;

    localparam logic [1:0] ADDR_DATA      = 2'd0;
    localparam logic [1:0] ADDR_CONTROL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS    = 2'd2;
    localparam logic [1:0] ADDR_FRAME_CNT = 2'd3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_LEVEL_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LEFT,
        ST_RIGHT
    } i2s_state_e;

    function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                                input logic ovf, input logic [7:0] level);
        logic [31:0] v;
        v = '0;
        v[STAT_EMPTY_BIT] = empty;
        v[STAT_FULL_BIT]  = full;
        v[STAT_OVF_BIT]   = ovf;
        v[STAT_LEVEL_LSB +: 8] = level;
        return v;
    endfunction

endpackage

// File: rtl/avs_i2s_rx_if.sv
// Avalon-MM slave bus bundle for the I2S receiver register port.
interface avs_i2s_rx_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] writedata;

    modport master (output address, read, write, writedata,
                    input  waitrequest, readdata);
    modport slave  (input  address, read, write, writedata,
                    output waitrequest, readdata);
endinterface

// File: rtl/i2s_rx_fifo.sv
// Show-ahead synchronous FIFO of stereo frames; head word visible without a pop.
module i2s_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [31:0]              i_data,
    output logic [31:0]              o_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_push;
    logic        w_do_pop;

    assign o_level   = r_wr_ptr - r_rd_ptr;
    assign o_empty   = (o_level == '0);
    assign o_full    = (o_level == (AW + 1)'(DEPTH));
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/avs_i2s_rx.sv
// Avalon-MM I2S receiver: synchronises an external Philips I2S stream, deserialises stereo
// frames and queues them for CPU/DMA reads.
module avs_i2s_rx
    import i2s_pkg::*;
#(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    avs_i2s_rx_if.slave   avs_s0,
    input  logic          avs_s0_export_i2s_sck,
    input  logic          avs_s0_export_i2s_ws,
    input  logic          avs_s0_export_i2s_sd
);
    localparam int         LW   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [4:0] DW_L = 5'(DW);

    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_ws_meta,  r_ws_sync;
    logic r_sd_meta,  r_sd_sync;

    logic        r_ws_prev;
    logic [15:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_left;

    i2s_state_e  r_state;
    i2s_state_e  w_state_nxt;

    logic        r_en;
    logic        r_ovf;
    logic [31:0] r_frame_cnt;

    logic        w_sck_rise;
    logic        w_ws_change;
    logic        w_bit_room;
    logic [15:0] w_slot_word;
    logic        w_fin_left;
    logic        w_push;
    logic        w_pop;
    logic        w_flush;
    logic        w_push_ok;
    logic        w_drop;
    logic        w_wr_ctrl;
    logic        w_wr_stat;
    logic        w_wr_cnt;
    logic [31:0] w_head;
    logic        w_empty;
    logic        w_full;
    logic [LW-1:0] w_level;
    logic        w_unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {r_sck_meta, r_sck_sync, r_sck_prev} <= '0;
            {r_ws_meta, r_ws_sync, r_sd_meta, r_sd_sync} <= '0;
        end else begin
            r_sck_meta <= avs_s0_export_i2s_sck;
            r_sck_sync <= r_sck_meta;
            r_sck_prev <= r_sck_sync;
            r_ws_meta  <= avs_s0_export_i2s_ws;
            r_ws_sync  <= r_ws_meta;
            r_sd_meta  <= avs_s0_export_i2s_sd;
            r_sd_sync  <= r_sd_meta;
        end
    end

    assign w_sck_rise  = r_sck_sync & ~r_sck_prev;
    assign w_ws_change = w_sck_rise & (r_ws_sync != r_ws_prev);
    assign w_bit_room  = (r_bit_cnt < DW_L);

    // Current bit lands MSB-first; once DW bits are in, later bits of the slot are dropped.
    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_slot_word = r_shift;
        if (w_bit_room) w_slot_word[4'd15 - r_bit_cnt[3:0]] = r_sd_sync;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ws_prev <= 1'b0;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_left    <= '0;
        end else if (w_sck_rise) begin
            r_ws_prev <= r_ws_sync;
            if (w_ws_change) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
                if (w_fin_left) r_left <= w_slot_word;
            end else begin
                r_shift <= w_slot_word;
                if (w_bit_room) r_bit_cnt <= r_bit_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fin_left  = 1'b0;
        w_push      = 1'b0;
        if (!r_en) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_SYNC;
                ST_SYNC:  if (w_ws_change && !r_ws_sync) w_state_nxt = ST_LEFT;
                ST_LEFT:  if (w_ws_change && r_ws_sync) begin
                              w_fin_left  = 1'b1;
                              w_state_nxt = ST_RIGHT;
                          end
                ST_RIGHT: if (w_ws_change && !r_ws_sync) begin
                              w_push      = 1'b1;
                              w_state_nxt = ST_LEFT;
                          end
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign w_pop     = avs_s0.read && (avs_s0.address == ADDR_DATA) && !w_empty;
    assign w_wr_ctrl = avs_s0.write && (avs_s0.address == ADDR_CONTROL);
    assign w_wr_stat = avs_s0.write && (avs_s0.address == ADDR_STATUS);
    assign w_wr_cnt  = avs_s0.write && (avs_s0.address == ADDR_FRAME_CNT);
    assign w_flush   = w_wr_ctrl && avs_s0.writedata[CTRL_FLUSH_BIT];
    assign w_push_ok = w_push & (~w_full | w_pop) & ~w_flush;
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_unused_wdata = &{1'b0, avs_s0.writedata[31:3]};

    i2s_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_data  ({r_left, w_slot_word}),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_level (w_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_en        <= 1'b0;
            r_ovf       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_wr_ctrl) r_en <= avs_s0.writedata[CTRL_EN_BIT];
            if (w_drop)
                r_ovf <= 1'b1;
            else if (w_wr_stat && avs_s0.writedata[STAT_OVF_BIT])
                r_ovf <= 1'b0;
            if (w_wr_cnt)       r_frame_cnt <= '0;
            else if (w_push_ok) r_frame_cnt <= r_frame_cnt + 32'd1;
        end
    end

    assign avs_s0.waitrequest = 1'b0;

    always_comb begin
        avs_s0.readdata = '0;
        if (avs_s0.read) begin
            case (avs_s0.address)
                ADDR_DATA:      if (!w_empty) avs_s0.readdata = w_head;
                ADDR_CONTROL:   avs_s0.readdata = {31'b0, r_en};
                ADDR_STATUS:    avs_s0.readdata = pack_status(w_empty, w_full, r_ovf, 8'(w_level));
                ADDR_FRAME_CNT: avs_s0.readdata = r_frame_cnt;
                default:        avs_s0.readdata = '0;
            endcase
        end
    end
endmodule
